dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port data memory in the MIPS pipeline. Requester 0 is the pipeline MEM stage (cpu_*); requester 1 is the external loader/debug port (ext_*). The block serialises accesses into one-cycle memory transactions and returns registered read data with a one-cycle ack pulse. CPU has fixed priority, with starvation protection for the external port.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arb_prio.sv | 35 +++
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data memory arbiter
package dmem_arb_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_EXT = 1'b1;

endpackage

// File: rtl/dmem_arb_prio.sv
// rtl/dmem_arb_prio.sv - fixed cpu priority with starvation override for ext
module dmem_arb_prio
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic             elig_cpu,
   input  logic             elig_ext,
   input  logic [CNT_W-1:0] starve_cnt,
   output logic             grant_valid,
   output logic             grant_owner,
   output logic [CNT_W-1:0] starve_nxt
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   always_comb begin
      grant_valid = elig_cpu | elig_ext;
      grant_owner = OWNER_CPU;
      starve_nxt  = starve_cnt;
      if (elig_cpu && elig_ext) begin
         if (starve_cnt >= LIMIT_C) begin
            grant_owner = OWNER_EXT;
            starve_nxt  = '0;
         end else if (starve_cnt != {CNT_W{1'b1}}) begin
            starve_nxt  = starve_cnt + 1'b1;
         end
      end else if (elig_ext) begin
         grant_owner = OWNER_EXT;
         starve_nxt  = '0;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter/sequencer for the single-port data memory
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_ack,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_stall,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t              state, state_nxt;
   logic                owner, owner_nxt;
   logic [CNT_W-1:0]    starve_cnt, starve_d, starve_nxt;
   logic [DATA_W-1:0]   rdata_q;

   logic                elig_cpu, elig_ext;
   logic                grant_valid, grant_owner;
   logic                owner_we;
   logic [ADDR_W-1:0]   owner_addr;
   logic [DATA_W-1:0]   owner_wdata;
   logic                in_serve, in_resp;

   assign in_serve = (state == SERVE);
   assign in_resp  = (state == RESP);

   // The requester acked this cycle may still hold req; it is only re-queued next cycle.
   assign elig_cpu = cpu_req & ~(in_resp & (owner == OWNER_CPU));
   assign elig_ext = ext_req & ~(in_resp & (owner == OWNER_EXT));

   dmem_arb_prio #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) u_prio (
      .elig_cpu    (elig_cpu),
      .elig_ext    (elig_ext),
      .starve_cnt  (starve_cnt),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner),
      .starve_nxt  (starve_nxt)
   );

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      starve_d  = starve_cnt;
      case (state)
         IDLE, RESP: begin
            starve_d = starve_nxt;
            if (grant_valid) begin
               state_nxt = SERVE;
               owner_nxt = grant_owner;
            end else begin
               state_nxt = IDLE;
            end
         end
         SERVE:   state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= OWNER_CPU;
         starve_cnt <= '0;
         rdata_q    <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         starve_cnt <= starve_d;
         if (in_serve && !owner_we)
            rdata_q <= mem_rdata;
      end
   end

   assign owner_we    = (owner == OWNER_EXT) ? ext_we    : cpu_we;
   assign owner_addr  = (owner == OWNER_EXT) ? ext_addr  : cpu_addr;
   assign owner_wdata = (owner == OWNER_EXT) ? ext_wdata : cpu_wdata;

   assign mem_read  = in_serve & ~owner_we;
   assign mem_write = in_serve &  owner_we;
   assign mem_addr  = in_serve ? owner_addr  : '0;
   assign mem_wdata = in_serve ? owner_wdata : '0;

   assign cpu_ack   = in_resp & (owner == OWNER_CPU);
   assign ext_ack   = in_resp & (owner == OWNER_EXT);
   assign cpu_rdata = cpu_ack ? rdata_q : '0;
   assign ext_rdata = ext_ack ? rdata_q : '0;
   assign cpu_stall = cpu_req & ~cpu_ack;
   assign ext_stall = ext_req & ~ext_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        ext_req, ext_we, ext_ack, ext_stall;
   logic [31:0] ext_addr, ext_wdata, ext_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] mem_model [0:15];

   int checks = 0;
   int errors = 0;

   dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .ext_req   (ext_req),
      .ext_we    (ext_we),
      .ext_addr  (ext_addr),
      .ext_wdata (ext_wdata),
      .ext_ack   (ext_ack),
      .ext_rdata (ext_rdata),
      .ext_stall (ext_stall),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem_model[i] <= '0;
      end else if (mem_write) begin
         mem_model[mem_addr[3:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem_model[mem_addr[3:0]];

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
      tick();
      tick();
      checks++;
      if ({cpu_ack, ext_ack, cpu_stall, ext_stall, mem_read, mem_write} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 000000",
                  {cpu_ack, ext_ack, cpu_stall, ext_stall, mem_read, mem_write});
      end
      checks++;
      if ({mem_addr, mem_wdata, cpu_rdata, ext_rdata} !== 128'd0) begin
         errors++;
         $display("FAIL reset_data got addr=%h wdata=%h crd=%h erd=%h want all 0",
                  mem_addr, mem_wdata, cpu_rdata, ext_rdata);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_cpu_write();
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'd5; cpu_wdata = 32'hDEAD;
      #1;
      checks++;
      if ({cpu_stall, mem_write, cpu_ack} !== 3'b100) begin
         errors++;
         $display("FAIL wr_idle got stall/mw/ack=%b want 100", {cpu_stall, mem_write, cpu_ack});
      end
      tick();
      checks++;
      if ({mem_read, mem_write, cpu_ack, cpu_stall} !== 4'b0101 || mem_addr !== 32'd5
          || mem_wdata !== 32'hDEAD) begin
         errors++;
         $display("FAIL wr_serve got mr/mw/ack/stall=%b addr=%h wdata=%h want 0101 5 dead",
                  {mem_read, mem_write, cpu_ack, cpu_stall}, mem_addr, mem_wdata);
      end
      tick();
      checks++;
      if ({cpu_ack, cpu_stall, mem_write, ext_ack} !== 4'b1000 || cpu_rdata !== 32'd0) begin
         errors++;
         $display("FAIL wr_ack got ack/stall/mw/eack=%b rdata=%h want 1000 0",
                  {cpu_ack, cpu_stall, mem_write, ext_ack}, cpu_rdata);
      end
      tick();
      cpu_req = 0; cpu_we = 0;
      #1;
      checks++;
      if ({cpu_ack, cpu_stall, mem_write, mem_read} !== 4'b0000) begin
         errors++;
         $display("FAIL wr_after got %b want 0000", {cpu_ack, cpu_stall, mem_write, mem_read});
      end
   endtask

   task automatic test_cpu_read();
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'd5; cpu_wdata = '0;
      #1;
      tick();
      checks++;
      if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 32'd5 || cpu_ack !== 1'b0) begin
         errors++;
         $display("FAIL rd_serve got mr/mw=%b addr=%h ack=%b want 10 5 0",
                  {mem_read, mem_write}, mem_addr, cpu_ack);
      end
      tick();
      checks++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hDEAD || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL rd_ack got ack=%b rdata=%h mr=%b want 1 dead 0",
                  cpu_ack, cpu_rdata, mem_read);
      end
      tick();
      cpu_req = 0;
      #1;
      checks++;
      if (cpu_ack !== 1'b0 || cpu_rdata !== 32'd0) begin
         errors++;
         $display("FAIL rd_after got ack=%b rdata=%h want 0 0", cpu_ack, cpu_rdata);
      end
   endtask

   task automatic test_ext_stream();
      for (int c = 0; c < 12; c++) begin
         int ph;
         ph = c % 3;
         if (ph == 0) begin
            ext_req = 1; ext_we = 1; ext_addr = 32'(c / 3); ext_wdata = 32'h100 + 32'(c / 3);
         end
         #1;
         checks++;
         if (ext_ack !== (ph == 2) || mem_write !== (ph == 1)
             || mem_addr !== ((ph == 1) ? 32'(c / 3) : 32'd0)
             || cpu_ack !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL ext_stream c=%0d got eack=%b mw=%b addr=%h cack=%b cstall=%b want %b %b %0d 0 0",
                     c, ext_ack, mem_write, mem_addr, cpu_ack, cpu_stall,
                     (ph == 2), (ph == 1), (ph == 1) ? c / 3 : 0);
         end
         tick();
      end
      ext_req = 0; ext_we = 0;
      #1;
      tick();
   endtask

   task automatic test_back_to_back();
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'd5;
      ext_req = 1; ext_we = 0; ext_addr = 32'd2;
      #1;
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_addr !== 32'd5) begin
         errors++;
         $display("FAIL b2b_serve_cpu got mr=%b addr=%h want 1 5", mem_read, mem_addr);
      end
      tick();
      checks++;
      if ({cpu_ack, ext_ack, ext_stall} !== 3'b101 || cpu_rdata !== 32'hDEAD || ext_rdata !== 32'd0) begin
         errors++;
         $display("FAIL b2b_ack_cpu got cack/eack/estall=%b crd=%h erd=%h want 101 dead 0",
                  {cpu_ack, ext_ack, ext_stall}, cpu_rdata, ext_rdata);
      end
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_addr !== 32'd2 || cpu_ack !== 1'b0) begin
         errors++;
         $display("FAIL b2b_serve_ext got mr=%b addr=%h cack=%b want 1 2 0", mem_read, mem_addr, cpu_ack);
      end
      tick();
      checks++;
      if ({ext_ack, cpu_ack, cpu_stall} !== 3'b101 || ext_rdata !== 32'h102 || cpu_rdata !== 32'd0) begin
         errors++;
         $display("FAIL b2b_ack_ext got eack/cack/cstall=%b erd=%h crd=%h want 101 102 0",
                  {ext_ack, cpu_ack, cpu_stall}, ext_rdata, cpu_rdata);
      end
      tick();
      ext_req = 0;
      #1;
      checks++;
      if (mem_read !== 1'b1 || mem_addr !== 32'd5) begin
         errors++;
         $display("FAIL b2b_serve_cpu2 got mr=%b addr=%h want 1 5", mem_read, mem_addr);
      end
      tick();
      checks++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hDEAD) begin
         errors++;
         $display("FAIL b2b_ack_cpu2 got ack=%b rdata=%h want 1 dead", cpu_ack, cpu_rdata);
      end
      tick();
      cpu_req = 0;
      #1;
      tick();
   endtask

   task automatic test_starvation();
      for (int r = 0; r < 4; r++) begin
         cpu_req = 1; cpu_we = 1; cpu_addr = 32'd8 + 32'(r); cpu_wdata = 32'h200 + 32'(r);
         ext_req = 1; ext_we = 0; ext_addr = 32'd2;
         #1;
         tick();
         checks++;
         if (mem_write !== 1'b1 || mem_addr !== 32'd8 + 32'(r)) begin
            errors++;
            $display("FAIL starve_cpu_win r=%0d got mw=%b addr=%h want 1 %0d", r, mem_write, mem_addr, 8 + r);
         end
         ext_req = 0;
         tick();
         checks++;
         if ({cpu_ack, ext_ack} !== 2'b10) begin
            errors++;
            $display("FAIL starve_cpu_ack r=%0d got cack/eack=%b want 10", r, {cpu_ack, ext_ack});
         end
         tick();
         cpu_req = 0;
         #1;
      end
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'd12; cpu_wdata = 32'h204;
      ext_req = 1;
      #1;
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'd2) begin
         errors++;
         $display("FAIL starve_ext_win got mr=%b mw=%b addr=%h want 1 0 2", mem_read, mem_write, mem_addr);
      end
      tick();
      checks++;
      if ({ext_ack, cpu_ack} !== 2'b10 || ext_rdata !== 32'h102) begin
         errors++;
         $display("FAIL starve_ext_ack got eack/cack=%b erd=%h want 10 102", {ext_ack, cpu_ack}, ext_rdata);
      end
      tick();
      ext_req = 0;
      #1;
      checks++;
      if (mem_write !== 1'b1 || mem_addr !== 32'd12) begin
         errors++;
         $display("FAIL starve_cpu_after got mw=%b addr=%h want 1 12", mem_write, mem_addr);
      end
      tick();
      tick();
      cpu_req = 0;
      #1;
      cpu_req = 1; cpu_addr = 32'd13; cpu_wdata = 32'h205;
      ext_req = 1;
      #1;
      tick();
      checks++;
      if (mem_write !== 1'b1 || mem_addr !== 32'd13) begin
         errors++;
         $display("FAIL starve_cleared got mw=%b addr=%h want 1 13", mem_write, mem_addr);
      end
      ext_req = 0;
      tick();
      tick();
      cpu_req = 0; cpu_we = 0;
      #1;
   endtask

   task automatic test_reset_serve();
      ext_req = 1; ext_we = 0; ext_addr = 32'd2;
      #1;
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_addr !== 32'd2) begin
         errors++;
         $display("FAIL rst_serve_pre got mr=%b addr=%h want 1 2", mem_read, mem_addr);
      end
      rst = 1; ext_req = 0;
      #1;
      tick();
      checks++;
      if ({ext_ack, cpu_ack, mem_read, mem_write} !== 4'b0000 || mem_addr !== 32'd0
          || ext_rdata !== 32'd0 || dut.starve_cnt !== 3'd0) begin
         errors++;
         $display("FAIL rst_serve got eack/cack/mr/mw=%b addr=%h erd=%h starve=%0d want 0000 0 0 0",
                  {ext_ack, cpu_ack, mem_read, mem_write}, mem_addr, ext_rdata, dut.starve_cnt);
      end
      rst = 0;
      tick();
      checks++;
      if ({ext_ack, mem_read, mem_write} !== 3'b000) begin
         errors++;
         $display("FAIL rst_serve_after got eack/mr/mw=%b want 000", {ext_ack, mem_read, mem_write});
      end
   endtask

   task automatic test_withdraw();
      ext_req = 1; ext_we = 1; ext_addr = 32'd3; ext_wdata = 32'h333;
      #1;
      tick();
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'd5;
      #1;
      checks++;
      if (cpu_stall !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 32'd3) begin
         errors++;
         $display("FAIL wd_serve got cstall=%b mw=%b addr=%h want 1 1 3", cpu_stall, mem_write, mem_addr);
      end
      tick();
      cpu_req = 0;
      #1;
      checks++;
      if (ext_ack !== 1'b1 || cpu_stall !== 1'b0 || cpu_ack !== 1'b0) begin
         errors++;
         $display("FAIL wd_resp got eack=%b cstall=%b cack=%b want 1 0 0", ext_ack, cpu_stall, cpu_ack);
      end
      tick();
      ext_req = 0; ext_we = 0;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({cpu_ack, ext_ack, mem_read, mem_write, cpu_stall} !== 5'b00000) begin
            errors++;
            $display("FAIL wd_idle c=%0d got %b want 00000", c,
                     {cpu_ack, ext_ack, mem_read, mem_write, cpu_stall});
         end
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_ext_stream();
      test_back_to_back();
      test_starvation();
      test_reset_serve();
      test_withdraw();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
